// File: rtl/ntt_pkg.sv
// Shared definitions for the poly_mul NTT datapath: controller state encoding
// and default geometry of the twiddle ROM.
package ntt_pkg;

  localparam int unsigned LOGN_MAX    = 7;
  localparam int          TF_ADDR_W   = 9;
  localparam int          TF_DATA_W   = 256;
  localparam int          TF_LOGN_W   = 3;
  localparam int          TF_INV_BASE = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tf_state_e;

endpackage

// File: rtl/tf_idx_cnt.sv
// Nested stage/group/butterfly counters for the twiddle walk; produces the
// table index k << (logn-1-s) for the current position.
module tf_idx_cnt
  import ntt_pkg::*;
#(
  parameter int LOGN_W = TF_LOGN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                adv,
  input  logic [LOGN_W-1:0]   logn,
  output logic [LOGN_MAX-1:0] idx,
  output logic [LOGN_W-1:0]   stage,
  output logic                last
);

  logic [LOGN_W-1:0]   s_q, s_d;
  logic [LOGN_MAX-1:0] g_q, g_d;
  logic [LOGN_MAX-1:0] k_q, k_d;
  logic [LOGN_W-1:0]   sh;
  logic [LOGN_MAX-1:0] k_max, g_max;
  logic                s_end, g_end, k_end;

  // k spans 0..2^s-1, g spans 0..2^(logn-1-s)-1
  always_comb begin
    sh    = logn - s_q - LOGN_W'(1);
    k_max = (LOGN_MAX'(1) << s_q) - LOGN_MAX'(1);
    g_max = (LOGN_MAX'(1) << sh) - LOGN_MAX'(1);
    k_end = (k_q == k_max);
    g_end = (g_q == g_max);
    s_end = (s_q == logn - LOGN_W'(1));
    last  = s_end && g_end && k_end;
    idx   = k_q << sh;
    stage = s_q;
  end

  always_comb begin
    s_d = s_q;
    g_d = g_q;
    k_d = k_q;
    if (clr) begin
      s_d = '0;
      g_d = '0;
      k_d = '0;
    end else if (adv) begin
      if (!k_end) begin
        k_d = k_q + LOGN_MAX'(1);
      end else begin
        k_d = '0;
        if (!g_end) begin
          g_d = g_q + LOGN_MAX'(1);
        end else begin
          g_d = '0;
          s_d = s_end ? '0 : s_q + LOGN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      g_q <= '0;
      k_q <= '0;
    end else begin
      s_q <= s_d;
      g_q <= g_d;
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/tf_addr_seq.sv
// Twiddle ROM read sequencer: walks every butterfly of one NTT/INTT, issues
// ROM reads and streams the registered ROM output to the butterfly unit.
module tf_addr_seq
  import ntt_pkg::*;
#(
  parameter int ADDR_W   = TF_ADDR_W,
  parameter int DATA_W   = TF_DATA_W,
  parameter int LOGN_W   = TF_LOGN_W,
  parameter int INV_BASE = TF_INV_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LOGN_W-1:0] logn,
  input  logic              inv,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_a,
  output logic              rom_en,
  output logic              rom_ren,
  input  logic [DATA_W-1:0] rom_q,
  output logic              tf_valid,
  input  logic              tf_ready,
  output logic [DATA_W-1:0] tf_data,
  output logic [LOGN_W-1:0] tf_stage,
  output logic              tf_last
);

  tf_state_e           state_q, state_d;
  logic [LOGN_W-1:0]   logn_q, logn_d;
  logic                inv_q, inv_d;
  logic                tf_valid_q, tf_valid_d;
  logic [LOGN_W-1:0]   tf_stage_q, tf_stage_d;
  logic                tf_last_q, tf_last_d;

  logic                start_ok;
  logic                issue;
  logic                hs;
  logic [LOGN_MAX-1:0] cnt_idx;
  logic [LOGN_W-1:0]   cnt_stage;
  logic                cnt_last;

  tf_idx_cnt #(
    .LOGN_W (LOGN_W)
  ) u_idx_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .adv   (issue),
    .logn  (logn_q),
    .idx   (cnt_idx),
    .stage (cnt_stage),
    .last  (cnt_last)
  );

  // A read may issue whenever the output register is empty or being drained;
  // since ROM Q holds while EN=0, a stalled word stays put without a skid buffer.
  always_comb begin
    start_ok = (state_q == ST_IDLE) && start && (logn != '0);
    issue    = (state_q == ST_RUN) && (!tf_valid_q || tf_ready);
    hs       = tf_valid_q && tf_ready;
  end

  always_comb begin
    state_d    = state_q;
    logn_d     = logn_q;
    inv_d      = inv_q;
    tf_valid_d = tf_valid_q;
    tf_stage_d = tf_stage_q;
    tf_last_d  = tf_last_q;

    if (issue) begin
      tf_valid_d = 1'b1;
      tf_stage_d = cnt_stage;
      tf_last_d  = cnt_last;
    end else if (hs) begin
      tf_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          logn_d  = logn;
          inv_d   = inv;
        end
      end
      ST_RUN: begin
        if (issue && cnt_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hs && tf_last_q) begin
          state_d    = ST_DONE;
          tf_stage_d = '0;
          tf_last_d  = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      logn_q     <= '0;
      inv_q      <= 1'b0;
      tf_valid_q <= 1'b0;
      tf_stage_q <= '0;
      tf_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      logn_q     <= logn_d;
      inv_q      <= inv_d;
      tf_valid_q <= tf_valid_d;
      tf_stage_q <= tf_stage_d;
      tf_last_q  <= tf_last_d;
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    rom_en   = issue;
    rom_ren  = 1'b1;
    rom_a    = ADDR_W'(cnt_idx) + (inv_q ? ADDR_W'(INV_BASE) : '0);
    tf_valid = tf_valid_q;
    tf_data  = rom_q;
    tf_stage = tf_stage_q;
    tf_last  = tf_last_q;
  end

endmodule

// File: tb/tb_tf_addr_seq.sv
// Randomized bench for tf_addr_seq: a ROM model behind the DUT and a reference
// list of (address, stage, last) built directly from the NTT loop nest.
module tb_tf_addr_seq;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 256;
  localparam int LOGN_W   = 3;
  localparam int INV_BASE = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LOGN_W-1:0] logn;
  logic              inv;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_a;
  logic              rom_en;
  logic              rom_ren;
  logic [DATA_W-1:0] rom_q;
  logic              tf_valid;
  logic              tf_ready;
  logic [DATA_W-1:0] tf_data;
  logic [LOGN_W-1:0] tf_stage;
  logic              tf_last;

  tf_addr_seq #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LOGN_W   (LOGN_W),
    .INV_BASE (INV_BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .logn     (logn),
    .inv      (inv),
    .busy     (busy),
    .done     (done),
    .rom_a    (rom_a),
    .rom_en   (rom_en),
    .rom_ren  (rom_ren),
    .rom_q    (rom_q),
    .tf_valid (tf_valid),
    .tf_ready (tf_ready),
    .tf_data  (tf_data),
    .tf_stage (tf_stage),
    .tf_last  (tf_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input int a);
    logic [31:0] w;
    w = (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    return {8{w}} ^ DATA_W'(a);
  endfunction

  always @(posedge clk) begin
    if (rom_en) rom_q <= rom_word(int'(rom_a));
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int addr;
    int stage;
    bit last;
  } tw_t;

  tw_t exp_iss[$];
  tw_t exp_hs[$];

  task automatic build(input int ln, input bit iv);
    int n, total, cnt;
    tw_t t;
    n = 1 << ln;
    total = (n / 2) * ln;
    cnt = 0;
    for (int s = 0; s < ln; s++) begin
      int h;
      h = 1 << s;
      for (int g = 0; g < n / (2 * h); g++) begin
        for (int k = 0; k < h; k++) begin
          t.addr  = (k * (n / (2 * h)) + (iv ? INV_BASE : 0)) % (1 << ADDR_W);
          t.stage = s;
          t.last  = (cnt == total - 1);
          exp_iss.push_back(t);
          exp_hs.push_back(t);
          cnt++;
        end
      end
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int               hs_count = 0;
  int               hs_base = 0;
  int               first_hs_cyc = 0;
  int               last_hs_cyc = 0;
  bit               prev_stall = 1'b0;
  logic [DATA_W-1:0] held;
  tw_t              mt;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", DATA_W'(tf_valid), DATA_W'(1));
        check_eq("stall_data", tf_data, held);
      end
      if (tf_valid && !tf_ready) check_eq("stall_en", DATA_W'(rom_en), DATA_W'(0));
      if (rom_en) begin
        check_eq("rom_ren", DATA_W'(rom_ren), DATA_W'(1));
        if (exp_iss.size() == 0) begin
          check_eq("extra_issue", DATA_W'(rom_en), DATA_W'(0));
        end else begin
          mt = exp_iss.pop_front();
          check_eq("rom_a", DATA_W'(rom_a), DATA_W'(mt.addr));
        end
      end
      if (tf_valid && tf_ready) begin
        if (exp_hs.size() == 0) begin
          check_eq("extra_hs", DATA_W'(tf_valid), DATA_W'(0));
        end else begin
          mt = exp_hs.pop_front();
          check_eq("tf_data", tf_data, rom_word(mt.addr));
          check_eq("tf_stage", DATA_W'(tf_stage), DATA_W'(mt.stage));
          check_eq("tf_last", DATA_W'(tf_last), DATA_W'(mt.last));
        end
        if (hs_count == hs_base) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        hs_count++;
      end
      prev_stall = tf_valid && !tf_ready;
      held       = tf_data;
    end
  end

  int ready_mode = 0;
  int stall_left = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        tf_ready = 1'b1;
      end else if (stall_left > 0) begin
        tf_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        tf_ready   = 1'b0;
        stall_left = 4;
      end else begin
        tf_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic pulse_start(input int ln, input bit iv);
    @(posedge clk);
    #1;
    start = 1'b1;
    logn  = LOGN_W'(ln);
    inv   = iv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_xform(input int ln, input bit iv, input int mode);
    int total;
    total = ((1 << ln) / 2) * ln;
    build(ln, iv);
    ready_mode = mode;
    hs_base    = hs_count;
    pulse_start(ln, iv);
    @(negedge clk);
    check_eq("busy_run", DATA_W'(busy), DATA_W'(1));
    check_eq("first_issue", DATA_W'(rom_en), DATA_W'(1));
    check_eq("valid_lat1", DATA_W'(tf_valid), DATA_W'(0));
    @(negedge clk);
    check_eq("valid_lat2", DATA_W'(tf_valid), DATA_W'(1));
    for (int i = 0; i < 20000 && done !== 1'b1; i++) @(negedge clk);
    check_eq("done_seen", DATA_W'(done), DATA_W'(1));
    if (done === 1'b1) begin
      check_eq("done_lat", DATA_W'(cyc), DATA_W'(last_hs_cyc + 1));
      check_eq("busy_done", DATA_W'(busy), DATA_W'(1));
      check_eq("hs_total", DATA_W'(hs_count - hs_base), DATA_W'(total));
      check_eq("hs_left", DATA_W'(exp_hs.size()), DATA_W'(0));
      check_eq("iss_left", DATA_W'(exp_iss.size()), DATA_W'(0));
      if (mode == 0) begin
        check_eq("no_gaps", DATA_W'(last_hs_cyc - first_hs_cyc + 1), DATA_W'(total));
      end
      @(negedge clk);
      check_eq("done_pulse", DATA_W'(done), DATA_W'(0));
      check_eq("busy_idle", DATA_W'(busy), DATA_W'(0));
    end
    exp_iss.delete();
    exp_hs.delete();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    logn     = '0;
    inv      = 1'b0;
    tf_ready = 1'b0;
    rom_q    = '0;
    #12;
    check_eq("rst_busy", DATA_W'(busy), DATA_W'(0));
    check_eq("rst_valid", DATA_W'(tf_valid), DATA_W'(0));
    check_eq("rst_rom_a", DATA_W'(rom_a), DATA_W'(0));
    check_eq("rst_en", DATA_W'(rom_en), DATA_W'(0));
    @(negedge clk);
    rst = 1'b0;

    run_xform(2, 1'b0, 0);
    run_xform(3, 1'b0, 0);
    run_xform(3, 1'b1, 0);
    run_xform(7, 1'b0, 1);
    run_xform(7, 1'b1, 1);

    // logn=0 must not leave IDLE
    pulse_start(0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("logn0_busy", DATA_W'(busy), DATA_W'(0));
      check_eq("logn0_en", DATA_W'(rom_en), DATA_W'(0));
    end

    // a second start mid-run must not disturb the stream
    fork
      run_xform(3, 1'b0, 0);
      begin
        repeat (6) @(posedge clk);
        #2;
        start = 1'b1;
        logn  = LOGN_W'(2);
        inv   = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        check_eq("restart_busy", DATA_W'(busy), DATA_W'(1));
      end
    join

    // asynchronous reset partway through a logn=4 transform
    build(4, 1'b0);
    ready_mode = 0;
    hs_base    = hs_count;
    pulse_start(4, 1'b0);
    for (int i = 0; i < 200 && (hs_count - hs_base) < 10; i++) @(negedge clk);
    check_eq("pre_rst_hs", DATA_W'(hs_count - hs_base), DATA_W'(10));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", DATA_W'(busy), DATA_W'(0));
    check_eq("arst_done", DATA_W'(done), DATA_W'(0));
    check_eq("arst_en", DATA_W'(rom_en), DATA_W'(0));
    check_eq("arst_rom_a", DATA_W'(rom_a), DATA_W'(0));
    check_eq("arst_valid", DATA_W'(tf_valid), DATA_W'(0));
    check_eq("arst_stage", DATA_W'(tf_stage), DATA_W'(0));
    check_eq("arst_last", DATA_W'(tf_last), DATA_W'(0));
    exp_iss.delete();
    exp_hs.delete();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", DATA_W'(done), DATA_W'(0));
    end
    run_xform(2, 1'b0, 0);

    for (int r = 0; r < 4; r++) begin
      run_xform(int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
